// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM encoding for the SPI configuration register bank.
package spi_reg_pkg;

    localparam int unsigned CMD_RD     = 7;
    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronises the SPI pins into clk and derives sck/cs edge pulses
// (the _c edge outputs are combinational from the synchronised stages).
module spi_slave_sync
    import spi_reg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic cs,
    input  logic si,
    output logic si_s,
    output logic sck_rise_c,
    output logic sck_fall_c,
    output logic cs_fall_c,
    output logic cs_rise_c
);

    logic [SYNC_DEPTH-1:0] sck_ff;
    logic [SYNC_DEPTH-1:0] cs_ff;
    logic [SYNC_DEPTH-1:0] si_ff;
    logic                  sck_q;
    logic                  cs_q;

    // cs resets as "selected" so a frame already in flight at reset release
    // never produces a cs fall; only a fresh deselect/select starts a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_ff <= '0;
            cs_ff  <= '0;
            si_ff  <= '0;
            sck_q  <= 1'b0;
            cs_q   <= 1'b0;
        end else begin
            sck_ff <= {sck_ff[SYNC_DEPTH-2:0], sck};
            cs_ff  <= {cs_ff[SYNC_DEPTH-2:0], cs};
            si_ff  <= {si_ff[SYNC_DEPTH-2:0], si};
            sck_q  <= sck_ff[SYNC_DEPTH-1];
            cs_q   <= cs_ff[SYNC_DEPTH-1];
        end
    end

    assign si_s       = si_ff[SYNC_DEPTH-1];
    assign sck_rise_c =  sck_ff[SYNC_DEPTH-1] & ~sck_q;
    assign sck_fall_c = ~sck_ff[SYNC_DEPTH-1] &  sck_q;
    assign cs_fall_c  = ~cs_ff[SYNC_DEPTH-1]  &  cs_q;
    assign cs_rise_c  =  cs_ff[SYNC_DEPTH-1]  & ~cs_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave exposing NREGS x DATA_W configuration registers.
// Optional burst mode (address auto-increment) with macro SPI_AUTOINC_EN.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int unsigned       NREGS     = 16,
    parameter int unsigned       ADDR_W    = 7,
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spi_sck,
    input  logic                    spi_cs,
    input  logic                    spi_si,
    output logic                    spi_so,
    output logic [NREGS*DATA_W-1:0] reg_q,
    output logic [NREGS-1:0]        reg_wr,
    output logic                    frame_err
);

    localparam int unsigned      CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic              si_s;
    logic              sck_rise;
    logic              sck_fall;
    logic              cs_fall;
    logic              cs_rise;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shift_in;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_q;
    logic              addr_ok;
    logic [7:0]        cmd_byte;
    logic              cmd_done;
    logic              word_done;
    logic              abort;
    logic [ADDR_W-1:0] look_addr;
    logic [DATA_W-1:0] look_word;

    spi_slave_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .sck        (spi_sck),
        .cs         (spi_cs),
        .si         (spi_si),
        .si_s       (si_s),
        .sck_rise_c (sck_rise),
        .sck_fall_c (sck_fall),
        .cs_fall_c  (cs_fall),
        .cs_rise_c  (cs_rise)
    );

    assign shift_in = {shreg[DATA_W-2:0], si_s};
    assign cmd_byte = {shreg[6:0], si_s};
    assign addr_ok  = 32'(addr_q) < NREGS;

    // A completing bit wins over a simultaneous cs rise: the word lands, no error.
    always_comb begin
        state_d   = state_q;
        cmd_done  = 1'b0;
        word_done = 1'b0;
        abort     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (sck_rise && bit_cnt == CMD_LAST) begin
                    cmd_done = 1'b1;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sck_rise && bit_cnt == DATA_LAST) begin
                    word_done = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
`ifdef SPI_AUTOINC_EN
                state_d = ST_DATA;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        if (cs_rise) begin
            abort   = (state_q == ST_CMD || state_q == ST_DATA) && (bit_cnt != '0)
                      && !cmd_done && !word_done;
            state_d = ST_IDLE;
        end
    end

    // Snapshot source for the next read word; out-of-range addresses read zero.
    always_comb begin
`ifdef SPI_AUTOINC_EN
        look_addr = (state_q == ST_DONE) ? addr_q + ADDR_W'(1) : cmd_byte[ADDR_W-1:0];
`else
        look_addr = cmd_byte[ADDR_W-1:0];
`endif
        look_word = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (look_addr == ADDR_W'(i)) look_word = reg_q[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            spi_so    <= 1'b0;
            reg_wr    <= '0;
            frame_err <= 1'b0;
            reg_q     <= {NREGS{RESET_VAL}};
        end else begin
            reg_wr    <= '0;
            frame_err <= abort | (word_done & ~rd_q & ~addr_ok);

            if (state_d != state_q || !(state_q == ST_CMD || state_q == ST_DATA)) bit_cnt <= '0;
            else if (sck_rise)                                                   bit_cnt <= bit_cnt + CNT_W'(1);

            if (cmd_done) begin
                rd_q   <= cmd_byte[CMD_RD];
                addr_q <= cmd_byte[ADDR_W-1:0];
                shreg  <= look_word;
            end else if (state_q == ST_DONE && state_d == ST_DATA) begin
                addr_q <= addr_q + ADDR_W'(1);
                shreg  <= look_word;
            end else if (sck_rise && (state_q == ST_CMD || state_q == ST_DATA)) begin
                shreg  <= shift_in;
            end

            if (word_done && !rd_q) begin
                for (int unsigned i = 0; i < NREGS; i++) begin
                    if (addr_q == ADDR_W'(i)) begin
                        reg_q[i*DATA_W +: DATA_W] <= shift_in;
                        reg_wr[i]                 <= 1'b1;
                    end
                end
            end

            // MISO only carries read data; everywhere else it idles low.
            if (state_q == ST_DATA && rd_q) begin
                if (sck_fall) spi_so <= shreg[DATA_W-1];
            end else begin
                spi_so <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomised bench for spi_reg_bank against a frame-level register model.
module tb_spi_reg_bank;

    localparam int NREGS  = 16;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam int HALF   = 4;

    typedef logic [255:0] chk_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    spi_sck = 1'b0;
    logic                    spi_cs = 1'b1;
    logic                    spi_si = 1'b0;
    logic                    spi_so;
    logic [NREGS*DATA_W-1:0] reg_q;
    logic [NREGS-1:0]        reg_wr;
    logic                    frame_err;

    int                n_checks = 0;
    int                n_bad = 0;
    int                err_cnt = 0;
    int                wr_cnt = 0;
    logic [DATA_W-1:0] last_wr_val = '0;
    logic [DATA_W-1:0] model [NREGS];
    logic [DATA_W-1:0] tx_words [$];
    logic [DATA_W-1:0] rx_q [$];
    logic              cmd_so;

    spi_reg_bank #(
        .NREGS     (NREGS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RESET_VAL ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sck   (spi_sck),
        .spi_cs    (spi_cs),
        .spi_si    (spi_si),
        .spi_so    (spi_so),
        .reg_q     (reg_q),
        .reg_wr    (reg_wr),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts write strobes and frame errors, captures written value.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) err_cnt++;
            wr_cnt += $countones(reg_wr);
            for (int i = 0; i < NREGS; i++)
                if (reg_wr[i]) last_wr_val = reg_q[i*DATA_W +: DATA_W];
        end
    end

    task automatic check(input string tag, input chk_t got, input chk_t exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic chk_t model_flat();
        chk_t f;
        f = '0;
        for (int i = 0; i < NREGS; i++) f[i*DATA_W +: DATA_W] = model[i];
        return f;
    endfunction

    // Drive one frame of nbits bits (command then tx_words), MSB first, mode 0.
    task automatic spi_frame(input logic [7:0] cmd, input int nbits);
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] tw;
        int                k;
        rx_q   = {};
        cmd_so = 1'b0;
        word   = '0;
        @(negedge clk);
        spi_cs = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            k = 0;
            if (b < 8) spi_si = cmd[7-b];
            else begin
                k      = (b - 8) % DATA_W;
                tw     = tx_words[(b - 8) / DATA_W];
                spi_si = tw[DATA_W-1-k];
            end
            repeat (HALF) @(negedge clk);
            if (b < 8) cmd_so = cmd_so | spi_so;
            else begin
                word = {word[DATA_W-2:0], spi_so};
                if (k == DATA_W - 1) rx_q.push_back(word);
            end
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        spi_cs = 1'b1;
        repeat (4*HALF) @(negedge clk);
    endtask

    // Predict the frame outcome from the protocol rules, run it, compare.
    task automatic run_frame(input logic [7:0] cmd, input int nbits);
        logic              rd;
        int                a, wa, nfull, neff, e_err, e_wr, err0, wr0;
        bit                partial, any_wr;
        logic [DATA_W-1:0] exp_rx [$];
        logic [DATA_W-1:0] exp_last;
        rd       = cmd[7];
        a        = int'(cmd[6:0]);
        err0     = err_cnt;
        wr0      = wr_cnt;
        e_err    = 0;
        e_wr     = 0;
        any_wr   = 0;
        exp_last = '0;
        nfull    = (nbits >= 8) ? (nbits - 8) / DATA_W : 0;
`ifdef SPI_AUTOINC_EN
        neff    = nfull;
        partial = (nbits > 8) && ((nbits - 8) % DATA_W != 0);
`else
        neff    = (nfull > 1) ? 1 : nfull;
        partial = (nbits > 8) && (nbits < 8 + DATA_W);
`endif
        if (nbits < 8) partial = (nbits >= 1);
        for (int w = 0; w < nfull; w++) begin
            wa = (a + w) % (1 << ADDR_W);
            if (w < neff) begin
                if (rd) exp_rx.push_back((wa < NREGS) ? model[wa] : '0);
                else if (wa < NREGS) begin
                    model[wa] = tx_words[w];
                    exp_last  = tx_words[w];
                    any_wr    = 1;
                    e_wr++;
                end else e_err++;
            end else if (rd) exp_rx.push_back('0);
        end
        if (partial) e_err++;

        spi_frame(cmd, nbits);

        check("frame_err_count", chk_t'(err_cnt - err0), chk_t'(e_err));
        check("reg_wr_count", chk_t'(wr_cnt - wr0), chk_t'(e_wr));
        check("reg_q", chk_t'(reg_q), model_flat());
        check("so_during_cmd", chk_t'(cmd_so), chk_t'(0));
        if (rd) begin
            check("rx_words", chk_t'(rx_q.size()), chk_t'(exp_rx.size()));
            for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
                check("rx_data", chk_t'(rx_q[i]), chk_t'(exp_rx[i]));
        end
        if (any_wr) check("wr_value_at_pulse", chk_t'(last_wr_val), chk_t'(exp_last));
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        repeat (5) @(negedge clk);
        check("reset_reg_q", chk_t'(reg_q), model_flat());
        check("reset_so", chk_t'(spi_so), chk_t'(0));
        check("reset_reg_wr", chk_t'(reg_wr), chk_t'(0));
        check("reset_frame_err", chk_t'(frame_err), chk_t'(0));
        rst = 1'b0;
        repeat (5) @(negedge clk);

        tx_words = {16'hBEEF};
        run_frame(8'h03, 8 + DATA_W);
        run_frame(8'h83, 8 + DATA_W);
        tx_words = {16'h1234};
        run_frame(8'h20, 8 + DATA_W);
        run_frame(8'hA0, 8 + DATA_W);
        tx_words = {16'hCAFE};
        run_frame(8'h05, 8 + 9);
        tx_words = {16'h1111, 16'h2222, 16'h3333};
        run_frame(8'h0F, 8 + 3*DATA_W);

        // Reset after 5 command bits, keep clocking with cs low, then reselect.
        begin
            logic [7:0] c;
            int         e0, w0;
            c = 8'h0A;
            @(negedge clk);
            spi_cs = 1'b0;
            for (int b = 0; b < 5; b++) begin
                spi_si = c[7-b];
                repeat (HALF) @(negedge clk);
                spi_sck = 1'b1;
                repeat (HALF) @(negedge clk);
                spi_sck = 1'b0;
            end
            rst = 1'b1;
            repeat (3) @(negedge clk);
            for (int i = 0; i < NREGS; i++) model[i] = '0;
            check("midreset_reg_q", chk_t'(reg_q), model_flat());
            check("midreset_so", chk_t'(spi_so), chk_t'(0));
            check("midreset_reg_wr", chk_t'(reg_wr), chk_t'(0));
            rst = 1'b0;
            e0 = err_cnt;
            w0 = wr_cnt;
            for (int b = 0; b < 12; b++) begin
                spi_si = 1'b1;
                repeat (HALF) @(negedge clk);
                spi_sck = 1'b1;
                repeat (HALF) @(negedge clk);
                spi_sck = 1'b0;
            end
            repeat (HALF) @(negedge clk);
            spi_cs = 1'b1;
            repeat (4*HALF) @(negedge clk);
            check("postreset_err", chk_t'(err_cnt - e0), chk_t'(0));
            check("postreset_wr", chk_t'(wr_cnt - w0), chk_t'(0));
            check("postreset_reg_q", chk_t'(reg_q), model_flat());
        end
        tx_words = {16'h5A5A};
        run_frame(8'h07, 8 + DATA_W);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] cmd;
            int         nb, nw;
            cmd[7]   = 1'($urandom_range(0, 1));
            cmd[6:0] = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 23));
            nw       = int'($urandom_range(1, 3));
            nb       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8 + 2*DATA_W))
                                                  : 8 + nw*DATA_W;
            tx_words = {};
            for (int i = 0; i < 3; i++) tx_words.push_back(DATA_W'($urandom));
            run_frame(cmd, nb);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
